// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer; in_ready is driven from a flop.
// Optional stall/bubble perf counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid_reg #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // State and entry registers; reset dominates flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_NOP;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_NOP;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Next-state and next-entry logic; an empty main entry always reads as a NOP bubble.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (in_fire) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
          state_d     = FULL;
        end else if (out_fire) begin
          main_data_d = '0;
          main_ctrl_d = CTRL_NOP;
          state_d     = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_data_d = '0;
          skid_ctrl_d = CTRL_NOP;
          state_d     = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = CTRL_NOP;
      skid_data_d = '0;
      skid_ctrl_d = CTRL_NOP;
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Saturating counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (!out_valid_q && out_ready && (bubble_q != CNT_MAX)) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed self-checking bench for pipe_stage_skid_reg (DATA_W=32, CTRL_W=16, CNT_W=2).
module tb_pipe_stage_skid_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 2;
  localparam logic [CTRL_W-1:0] NOP = 16'h00F0;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_skid_reg #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CTRL_NOP(NOP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CTRL_W-1:0] ctl_of(input logic [DATA_W-1:0] d);
    return d[15:0] ^ 16'hA5C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = ctl_of(d);
  endtask

  // Checks the visible output entry; an invalid entry must read as data 0 / NOP.
  task automatic expect_out(input string tag, input logic v, input logic [DATA_W-1:0] d,
                            input logic rdy);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".out_data"},  64'(out_data),  v ? 64'(d) : 64'd0);
    check({tag, ".out_ctrl"},  64'(out_ctrl),  v ? 64'(ctl_of(d)) : 64'(NOP));
    check({tag, ".in_ready"},  64'(in_ready),  64'(rdy));
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h99);

    // Reset held two cycles with in_valid high: nothing captured.
    cyc(); expect_out("rst1", 1'b0, 0, 1'b1);
    cyc(); expect_out("rst2", 1'b0, 0, 1'b1);
    check("rst.stall",  64'(stall_cnt),  64'd0);
    check("rst.bubble", 64'(bubble_cnt), 64'd0);
    drive(1'b0, 0);
    reset_n = 1'b1;
    cyc(); expect_out("rst_rel", 1'b0, 0, 1'b1);

    // Back-to-back stream at one-cycle latency.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h11 + 32'(k));
      cyc(); expect_out($sformatf("stream%0d", k), 1'b1, 32'h11 + 32'(k), 1'b1);
    end
    drive(1'b0, 0);
    cyc(); expect_out("stream_drain", 1'b0, 0, 1'b1);

    // Backpressure fills main then skid; third offer is held off.
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    cyc(); expect_out("bp_a", 1'b1, 32'hA, 1'b1);
    drive(1'b1, 32'hB);
    cyc(); expect_out("bp_b", 1'b1, 32'hA, 1'b0);
    drive(1'b1, 32'hC);
    cyc(); expect_out("bp_c_held", 1'b1, 32'hA, 1'b0);
    cyc(); expect_out("bp_c_held2", 1'b1, 32'hA, 1'b0);
    out_ready = 1'b1;
    cyc(); expect_out("bp_out_b", 1'b1, 32'hB, 1'b1);
    cyc(); expect_out("bp_out_c", 1'b1, 32'hC, 1'b1);
    drive(1'b0, 0);
    cyc(); expect_out("bp_drain", 1'b0, 0, 1'b1);

    // Flush while FULL with a new offer present.
    out_ready = 1'b0;
    drive(1'b1, 32'h30);
    cyc();
    drive(1'b1, 32'h31);
    cyc(); expect_out("fl_full", 1'b1, 32'h30, 1'b0);
    drive(1'b1, 32'hD);
    flush     = 1'b1;
    out_ready = 1'b1;
    cyc(); expect_out("fl_full_flush", 1'b0, 0, 1'b1);
    flush = 1'b0;
    drive(1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); expect_out($sformatf("fl_after%0d", k), 1'b0, 0, 1'b1);
    end

    // Flush in ONE while an entry is accepted: the incoming entry is dropped.
    drive(1'b1, 32'h0E0);
    out_ready = 1'b0;
    cyc(); expect_out("fl1_load", 1'b1, 32'h0E0, 1'b1);
    drive(1'b1, 32'h0E1);
    flush = 1'b1;
    cyc(); expect_out("fl1_flush", 1'b0, 0, 1'b1);
    flush = 1'b0;
    drive(1'b0, 0);
    out_ready = 1'b1;
    cyc(); expect_out("fl1_after", 1'b0, 0, 1'b1);

    // Reset while FULL, then a normal stream.
    out_ready = 1'b0;
    drive(1'b1, 32'h40);
    cyc();
    drive(1'b1, 32'h41);
    cyc(); expect_out("rf_full", 1'b1, 32'h40, 1'b0);
    drive(1'b1, 32'h42);
    reset_n = 1'b0;
    flush   = 1'b1;
    cyc(); expect_out("rf_rst", 1'b0, 0, 1'b1);
    flush   = 1'b0;
    reset_n = 1'b1;
    drive(1'b0, 0);
    out_ready = 1'b1;
    cyc(); expect_out("rf_rel", 1'b0, 0, 1'b1);
    drive(1'b1, 32'h21);
    cyc(); expect_out("rf_s21", 1'b1, 32'h21, 1'b1);
    drive(1'b1, 32'h22);
    cyc(); expect_out("rf_s22", 1'b1, 32'h22, 1'b1);
    drive(1'b0, 0);
    cyc(); expect_out("rf_drain", 1'b0, 0, 1'b1);

    // Perf counters: reset clears, bubbles count, stalls saturate at 3, flush keeps them.
    reset_n = 1'b0;
    cyc();
    check("pc_rst.stall",  64'(stall_cnt),  64'd0);
    check("pc_rst.bubble", 64'(bubble_cnt), 64'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    cyc(); cyc();
    check("pc_bubble2", 64'(bubble_cnt), PERF_EN ? 64'd2 : 64'd0);
    check("pc_stall0",  64'(stall_cnt),  64'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h50);
    cyc();
    drive(1'b0, 0);
    for (int k = 0; k < 3; k++) cyc();
    check("pc_stall3", 64'(stall_cnt), PERF_EN ? 64'd3 : 64'd0);
    for (int k = 0; k < 5; k++) cyc();
    check("pc_stall_sat", 64'(stall_cnt),  PERF_EN ? 64'd3 : 64'd0);
    check("pc_bubble_hold", 64'(bubble_cnt), PERF_EN ? 64'd2 : 64'd0);
    expect_out("pc_hold", 1'b1, 32'h50, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("pc_flush.stall",  64'(stall_cnt),  PERF_EN ? 64'd3 : 64'd0);
    check("pc_flush.bubble", 64'(bubble_cnt), PERF_EN ? 64'd2 : 64'd0);
    expect_out("pc_flushed", 1'b0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
